// File: rtl/sinc_timing_pkg.sv
// Shared types and defaults for the sinc_timing pulse timing stage.
package sinc_timing_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MIN_PERIOD_DEF = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level, with a rising-edge pulse
// taken from the synchronised side.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic [2:0] sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sh <= '0;
        else     sh <= {sh[1:0], d};
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/sinc_timing.sv
// Pulse timing stage: period counter and IDLE/RUN/DONE FSM producing sinc and gate.
// Define SINC_EXT_TRIG_EN to add the external trigger ports (i_trig_ext, i_sel_ext).
module sinc_timing
    import sinc_timing_pkg::*;
#(
    parameter int unsigned NB_REG     = 32,
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [NB_REG-1:0] i_periodo,
    input  logic [NB_REG-1:0] i_ancho,
    input  logic [NB_REG-1:0] i_npulsos,
`ifdef SINC_EXT_TRIG_EN
    input  logic              i_trig_ext,
    input  logic              i_sel_ext,
`endif
    output logic              o_sinc,
    output logic              o_gate,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [NB_REG-1:0] o_pulse_cnt
);

    localparam logic [NB_REG-1:0] MIN_P = NB_REG'(MIN_PERIOD);
    localparam logic [NB_REG-1:0] ONE   = NB_REG'(1);

    state_t            state, state_nx;
    logic [NB_REG-1:0] cnt, cnt_nx;
    logic [NB_REG-1:0] p_reg, p_nx, w_reg, w_nx, n_reg, n_nx;
    logic [NB_REG-1:0] pcnt_nx, w_new;
    logic              sinc_nx, gate_nx, busy_nx, done_nx, err_nx;
    logic              per_ok, at_end, trig_ok;

`ifdef SINC_EXT_TRIG_EN
    logic trig_rise, overrun, overrun_nx;

    sync_2ff u_sync (
        .clk  (i_clk),
        .rst  (i_rst),
        .d    (i_trig_ext),
        .rise (trig_rise)
    );

    assign trig_ok = ~i_sel_ext | trig_rise;
`else
    assign trig_ok = 1'b1;
`endif

    assign per_ok = (i_periodo >= MIN_P);
    assign at_end = (cnt == p_reg - ONE);
    // Gate is clamped to P-1 so the last cycle of every period is always gate-low
    assign w_new  = (i_ancho > i_periodo - ONE) ? i_periodo - ONE : i_ancho;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        p_nx     = p_reg;
        w_nx     = w_reg;
        n_nx     = n_reg;
        pcnt_nx  = o_pulse_cnt;
        sinc_nx  = 1'b0;
        gate_nx  = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        err_nx   = i_enable & ~per_ok;
`ifdef SINC_EXT_TRIG_EN
        overrun_nx = overrun;
`endif
        case (state)
            IDLE: begin
                if (i_enable && per_ok && trig_ok) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                    p_nx     = i_periodo;
                    w_nx     = w_new;
                    n_nx     = i_npulsos;
                    pcnt_nx  = ONE;
                    sinc_nx  = 1'b1;
                    gate_nx  = (w_new != '0);
                    busy_nx  = 1'b1;
`ifdef SINC_EXT_TRIG_EN
                    overrun_nx = 1'b0;
`endif
                end
            end
            RUN: begin
                busy_nx = 1'b1;
                if (!at_end) begin
                    cnt_nx  = cnt + ONE;
                    gate_nx = (cnt + ONE < w_reg);
                end else if (!i_enable) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else if (n_reg != '0 && o_pulse_cnt == n_reg) begin
                    state_nx = DONE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else if (!per_ok) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else if (trig_ok) begin
                    cnt_nx  = '0;
                    p_nx    = i_periodo;
                    w_nx    = w_new;
                    n_nx    = i_npulsos;
                    pcnt_nx = o_pulse_cnt + ONE;
                    sinc_nx = 1'b1;
                    gate_nx = (w_new != '0);
                end
`ifdef SINC_EXT_TRIG_EN
                if (i_sel_ext && trig_rise && !at_end)
                    overrun_nx = 1'b1;
`endif
            end
            DONE: begin
                if (!i_enable) state_nx = IDLE;
                else           done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
`ifdef SINC_EXT_TRIG_EN
        err_nx = err_nx | overrun_nx;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            p_reg       <= '0;
            w_reg       <= '0;
            n_reg       <= '0;
            o_sinc      <= 1'b0;
            o_gate      <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_pulse_cnt <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            p_reg       <= p_nx;
            w_reg       <= w_nx;
            n_reg       <= n_nx;
            o_sinc      <= sinc_nx;
            o_gate      <= gate_nx;
            o_busy      <= busy_nx;
            o_done      <= done_nx;
            o_err       <= err_nx;
            o_pulse_cnt <= pcnt_nx;
        end
    end

`ifdef SINC_EXT_TRIG_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) overrun <= 1'b0;
        else       overrun <= overrun_nx;
    end
`endif

endmodule

// File: tb/tb_sinc_timing.sv
// Self-checking bench for sinc_timing: vector table, directed corner sequences,
// and randomized stimulus against a behavioural model.
module tb_sinc_timing;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [31:0] per = 32'd10;
    logic [31:0] anc = 32'd4;
    logic [31:0] np  = 32'd0;
    logic        o_sinc, o_gate, o_busy, o_done, o_err;
    logic [31:0] o_pulse_cnt;

    int checks = 0;
    int errors = 0;

    sinc_timing #(.NB_REG(32), .MIN_PERIOD(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (en),
        .i_periodo   (per),
        .i_ancho     (anc),
        .i_npulsos   (np),
        .o_sinc      (o_sinc),
        .o_gate      (o_gate),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_pulse_cnt (o_pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 running, 2 burst done
    int          m_mode;
    logic [31:0] m_phase, m_P, m_W, m_N, m_cnt;
    bit          m_sinc, m_gate, m_busy, m_done, m_err;

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_P = 0; m_W = 0; m_N = 0; m_cnt = 0;
        m_sinc = 0; m_gate = 0; m_busy = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit start = 0;
        m_err = en && (per < 2);
        case (m_mode)
            0: if (en && per >= 2) begin start = 1; m_cnt = 0; end
            1: begin
                if (m_phase < m_P - 1)             m_phase++;
                else if (!en)                      m_mode = 0;
                else if (m_N != 0 && m_cnt == m_N) m_mode = 2;
                else if (per < 2)                  m_mode = 0;
                else                               start = 1;
            end
            default: if (!en) m_mode = 0;
        endcase
        if (start) begin
            m_mode = 1; m_phase = 0; m_P = per; m_N = np;
            m_W = (anc < per) ? anc : per - 1;
            m_cnt++;
        end
        m_sinc = start;
        m_gate = (m_mode == 1) && (m_phase < m_W);
        m_busy = (m_mode == 1);
        m_done = (m_mode == 2);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_sinc", o_sinc, m_sinc);
            chk("model_gate", o_gate, m_gate);
            chk("model_busy", o_busy, m_busy);
            chk("model_done", o_done, m_done);
            chk("model_err",  o_err,  m_err);
            chk("model_pcnt", o_pulse_cnt, m_cnt);
        end
    end

    typedef struct {
        bit          en;
        logic [31:0] per, anc, np;
        bit          sinc, gate, busy, done, err;
        logic [31:0] pcnt;
    } vec_t;

    function automatic vec_t mk(bit e, int p, int a, int n, bit s, bit g, bit b, bit d, bit r, int c);
        vec_t v;
        v.en = e; v.per = p; v.anc = a; v.np = n;
        v.sinc = s; v.gate = g; v.busy = b; v.done = d; v.err = r; v.pcnt = c;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_idle();
        bit ok = 0;
        en = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (!o_busy && !o_done) ok = 1;
        end
        chk("reach_idle", {31'd0, ok}, 32'd1);
    endtask

    vec_t tbl[24];
    int   st[$];
    int   g, s, a0, a1, a2;

    initial begin
        tbl[0]  = mk(0, 10, 4, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 10, 4, 0, 1, 1, 1, 0, 0, 1);
        tbl[2]  = mk(1, 10, 4, 0, 0, 1, 1, 0, 0, 1);
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = mk(1, 10, 4, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 6; i <= 10; i++) tbl[i] = tbl[5];
        tbl[11] = mk(1, 10, 4, 0, 1, 1, 1, 0, 0, 2);
        tbl[12] = mk(1, 10, 4, 0, 0, 1, 1, 0, 0, 2);
        tbl[13] = mk(0, 10, 4, 0, 0, 1, 1, 0, 0, 2);
        tbl[14] = tbl[13];
        tbl[15] = mk(0, 10, 4, 0, 0, 0, 1, 0, 0, 2);
        for (int i = 16; i <= 20; i++) tbl[i] = tbl[15];
        tbl[21] = mk(0, 10, 4, 0, 0, 0, 0, 0, 0, 2);
        tbl[22] = mk(1, 1,  4, 0, 0, 0, 0, 0, 1, 2);
        tbl[23] = mk(1, 12, 0, 0, 1, 0, 1, 0, 0, 1);

        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs", {26'd0, o_sinc, o_gate, o_busy, o_done, o_err, 1'b0}, 32'd0);
        chk("rst_pcnt", o_pulse_cnt, 32'd0);
        rst = 0;

        for (int i = 0; i < 24; i++) begin
            en = tbl[i].en; per = tbl[i].per; anc = tbl[i].anc; np = tbl[i].np;
            step();
            chk($sformatf("vec%0d_sinc", i), o_sinc, tbl[i].sinc);
            chk($sformatf("vec%0d_gate", i), o_gate, tbl[i].gate);
            chk($sformatf("vec%0d_busy", i), o_busy, tbl[i].busy);
            chk($sformatf("vec%0d_done", i), o_done, tbl[i].done);
            chk($sformatf("vec%0d_err", i),  o_err,  tbl[i].err);
            chk($sformatf("vec%0d_pcnt", i), o_pulse_cnt, tbl[i].pcnt);
        end

        // Burst of three pulses, then DONE held until enable drops
        go_idle();
        per = 8; anc = 3; np = 3; en = 1;
        st.delete();
        for (int k = 0; k < 40; k++) begin
            step();
            if (o_sinc) st.push_back(k);
            if (k == 24 || k == 39) begin
                chk("burst_done", o_done, 1);
                chk("burst_busy", o_busy, 0);
            end
        end
        chk("burst_nsinc", st.size(), 3);
        a0 = st.size() > 0 ? st[0] : -1;
        a1 = st.size() > 1 ? st[1] : -1;
        a2 = st.size() > 2 ? st[2] : -1;
        chk("burst_t0", a0, 0);
        chk("burst_t1", a1, 8);
        chk("burst_t2", a2, 16);
        en = 0;
        step();
        chk("burst_done_clr", o_done, 0);

        // Gate clamp to P-1, then zero-width gate
        go_idle();
        per = 10; anc = 50; np = 0; en = 1;
        g = 0;
        for (int k = 0; k < 20; k++) begin step(); g += int'(o_gate); end
        chk("clamp_gate_cycles", g, 18);
        anc = 0; g = 0; s = 0;
        for (int k = 0; k < 30; k++) begin step(); g += int'(o_gate); s += int'(o_sinc); end
        chk("zero_gate_cycles", g, 0);
        chk("zero_gate_sincs", s, 3);

        // Illegal period, then mid-period PRI change taking effect at the next sinc
        go_idle();
        per = 1; anc = 5; np = 0; en = 1;
        step();
        chk("short_per_err", o_err, 1);
        chk("short_per_sinc", o_sinc, 0);
        per = 12;
        step();
        chk("restart_sinc", o_sinc, 1);
        for (int k = 1; k <= 3; k++) step();
        per = 20;
        st.delete();
        for (int k = 4; k <= 40; k++) begin
            step();
            if (o_sinc) st.push_back(k);
        end
        chk("pri_nsinc", st.size(), 2);
        a0 = st.size() > 0 ? st[0] : -1;
        a1 = st.size() > 1 ? st[1] : -1;
        chk("pri_old_len", a0, 12);
        chk("pri_new_len", a1, 32);

        // Asynchronous reset while the gate is high
        go_idle();
        per = 10; anc = 4; en = 1;
        for (int k = 0; k < 3; k++) step();
        chk("pre_rst_gate", o_gate, 1);
        #1 rst = 1;
        #1;
        chk("async_rst_gate", o_gate, 0);
        chk("async_rst_busy", o_busy, 0);
        chk("async_rst_pcnt", o_pulse_cnt, 0);
        @(negedge clk);
        rst = 0;
        step();
        chk("post_rst_sinc", o_sinc, 1);
        chk("post_rst_pcnt", o_pulse_cnt, 1);

        // Randomized stimulus, checked by the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            step();
            r = int'($urandom_range(0, 299));
            if (r < 18) begin
                case ($urandom_range(0, 9))
                    0:       per = 0;
                    1:       per = 1;
                    default: per = $urandom_range(2, 12);
                endcase
            end else if (r < 30) anc = $urandom_range(0, 14);
            else if (r < 39)     np = $urandom_range(0, 3);
            else if (r < 51)     en = ~en;
            else if (r == 299) begin
                rst = 1;
                step();
                rst = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
